// File: rtl/des_block_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : des_block_packer_if
// Purpose  : Byte-stream input and 64-bit block output bundle for the DES
//            plaintext block packer.
// Revision : 1.0 - initial release
// ============================================================================
interface des_block_packer_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [64:1] block;
    logic        block_valid;
    logic        block_last;
    logic        block_ready;
    logic [15:0] blk_cnt;

    // master: byte producer / block consumer side; slave: the packer
    modport master (
        output in_byte, in_valid, in_last, block_ready,
        input  in_ready, block, block_valid, block_last, blk_cnt
    );

    modport slave (
        input  in_byte, in_valid, in_last, block_ready,
        output in_ready, block, block_valid, block_last, blk_cnt
    );
endinterface
`default_nettype wire

// File: rtl/des_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : des_block_packer
// Purpose  : Packs a plaintext byte stream into 64-bit DES blocks ([64:1],
//            first byte in [64:57]) with optional PKCS#7 padding.
// Revision : 1.0 - initial release
// ============================================================================
module des_block_packer #(
    parameter bit PAD_EN = 1'b1
) (
    input wire                 clk,
    input wire                 rst,
    des_block_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [64:1] c_PAD_BLOCK = {8{8'h08}};

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [64:1] r_buf;
    logic        r_pend_pad;
    logic [2:0]  r_pad;
    logic        r_in_ready;
    logic        r_block_valid;
    logic        r_block_last;
    logic [15:0] r_blk_cnt;

    logic        w_accept;
    logic        w_handshake;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_handshake = r_block_valid & bus.block_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_idx         <= 3'd0;
            r_buf         <= '0;
            r_pend_pad    <= 1'b0;
            r_pad         <= 3'd0;
            r_in_ready    <= 1'b1;
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
            r_blk_cnt     <= 16'd0;
        end else begin
            if (w_handshake) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end

            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < 8; k++) begin
                            if (3'(k) == r_idx) begin
                                r_buf[64-8*k -: 8] <= bus.in_byte;
                            end
                        end
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            // A full final block still needs a whole pad block behind it
                            r_state       <= S_HOLD;
                            r_in_ready    <= 1'b0;
                            r_block_valid <= 1'b1;
                            r_block_last  <= bus.in_last & ~PAD_EN;
                            r_pend_pad    <= bus.in_last & PAD_EN;
                        end else if (bus.in_last) begin
                            r_in_ready <= 1'b0;
                            if (PAD_EN) begin
                                r_state <= S_PAD;
                                r_pad   <= 3'd7 - r_idx;
                            end else begin
                                // Tail bytes are already zero from the buffer clear
                                r_state       <= S_HOLD;
                                r_block_valid <= 1'b1;
                                r_block_last  <= 1'b1;
                            end
                        end
                    end
                end

                S_PAD: begin
                    for (int k = 0; k < 8; k++) begin
                        if (3'(k) >= r_idx) begin
                            r_buf[64-8*k -: 8] <= {5'd0, r_pad};
                        end
                    end
                    r_state       <= S_HOLD;
                    r_block_valid <= 1'b1;
                    r_block_last  <= 1'b1;
                end

                S_HOLD: begin
                    if (w_handshake) begin
                        if (r_pend_pad) begin
                            r_buf        <= c_PAD_BLOCK;
                            r_block_last <= 1'b1;
                            r_pend_pad   <= 1'b0;
                        end else begin
                            r_state       <= S_FILL;
                            r_idx         <= 3'd0;
                            r_buf         <= '0;
                            r_in_ready    <= 1'b1;
                            r_block_valid <= 1'b0;
                            r_block_last  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.block       = r_buf;
    assign bus.block_valid = r_block_valid;
    assign bus.block_last  = r_block_last;
    assign bus.blk_cnt     = r_blk_cnt;

endmodule
`default_nettype wire
